mt_control_unit: RTL and testbench

MT_CONTROL_UNIT -- requirements
Module: mt_control_unit

---
 rtl/mt_control_unit.sv | 267 ++++++++++++++++++++++++++
 tb/tb_mt_control_unit.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/mt_control_unit.sv
// Multi-threaded instruction decode/control unit with per-hart LR/SC reservations.
// Optional feature: define CUSTOM0_DECODE_EN to decode custom-0 (0001011) as an ALU op.
module mt_control_unit #(
  parameter int unsigned NUM_HARTS = 16,
  parameter int unsigned HART_ID_W = $clog2(NUM_HARTS)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic                 i_stall,
  input  logic [HART_ID_W-1:0] i_hart_id,
  input  logic [6:0]           i_opcode,
  input  logic [2:0]           i_funct3,
  input  logic [6:0]           i_funct7,
  output logic                 o_valid,
  output logic [HART_ID_W-1:0] o_hart_id,
  output logic [2:0]           o_immSel,
  output logic                 o_brmuxsel,
  output logic                 o_br_signed,
  output logic                 o_is_branch,
  output logic                 o_is_jump,
  output logic                 o_aluop1sel,
  output logic                 o_aluop2sel,
  output logic [2:0]           o_ALUctrl,
  output logic                 o_MemWr,
  output logic                 o_regWE,
  output logic                 o_load,
  output logic [1:0]           o_WBSel,
  output logic                 o_slt_op,
  output logic                 o_store_cond,
  output logic                 o_sc_fail,
  output logic                 o_illegal,
  output logic [NUM_HARTS-1:0] o_res_valid
);

  localparam int unsigned OPC_W = 7;

  localparam logic [OPC_W-1:0] OP_R      = 7'b0110011;
  localparam logic [OPC_W-1:0] OP_I      = 7'b0010011;
  localparam logic [OPC_W-1:0] OP_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OP_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OP_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OP_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OP_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OP_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OP_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OP_SYSTEM = 7'b1110011;
  localparam logic [OPC_W-1:0] OP_AMO    = 7'b0101111;
`ifdef CUSTOM0_DECODE_EN
  localparam logic [OPC_W-1:0] OP_CUSTOM0 = 7'b0001011;
`endif

  typedef struct packed {
    logic [2:0] imm_sel;
    logic       brmuxsel;
    logic       br_signed;
    logic       is_branch;
    logic       is_jump;
    logic       aluop1sel;
    logic       aluop2sel;
    logic [2:0] alu_ctrl;
    logic       mem_wr;
    logic       reg_we;
    logic       load;
    logic [1:0] wb_sel;
    logic       slt_op;
    logic       store_cond;
  } ctrl_t;

  ctrl_t                  dec_c;
  logic                   illegal_c;
  logic                   is_lr_c;
  logic                   is_sc_c;
  logic                   is_store_c;
  logic                   accept_c;
  logic [NUM_HARTS-1:0]   res_next_c;

  ctrl_t                  ctrl_q;
  logic                   valid_q;
  logic [HART_ID_W-1:0]   hart_q;
  logic                   sc_fail_q;
  logic                   illegal_q;
  logic [NUM_HARTS-1:0]   res_q;

  // Combinational opcode/funct decode into control fields.
  always_comb begin
    dec_c      = '0;
    illegal_c  = 1'b0;
    is_lr_c    = 1'b0;
    is_sc_c    = 1'b0;
    is_store_c = 1'b0;
    unique case (i_opcode)
      OP_R, OP_I: begin
        dec_c.wb_sel   = 2'b01;
        dec_c.reg_we   = 1'b1;
        dec_c.alu_ctrl = 3'b010;
        if (i_opcode == OP_R && i_funct3 == 3'b000 && i_funct7 == 7'b0100000) begin
          dec_c.alu_ctrl = 3'b001;
        end
        if (i_funct3 == 3'b010 || i_funct3 == 3'b011) begin
          dec_c.slt_op    = 1'b1;
          dec_c.wb_sel    = 2'b11;
          dec_c.br_signed = (i_funct3 == 3'b010);
        end
        if (i_opcode == OP_I) begin
          dec_c.imm_sel   = 3'b001;
          dec_c.aluop2sel = 1'b1;
          dec_c.brmuxsel  = 1'b1;
        end
      end
      OP_LOAD: begin
        dec_c.load      = 1'b1;
        dec_c.imm_sel   = 3'b001;
        dec_c.aluop2sel = 1'b1;
        dec_c.reg_we    = 1'b1;
      end
      OP_STORE: begin
        dec_c.imm_sel   = 3'b010;
        dec_c.aluop2sel = 1'b1;
        dec_c.mem_wr    = 1'b1;
        is_store_c      = 1'b1;
      end
      OP_BRANCH: begin
        dec_c.imm_sel   = 3'b011;
        dec_c.aluop1sel = 1'b1;
        dec_c.aluop2sel = 1'b1;
        dec_c.is_branch = 1'b1;
        dec_c.br_signed = (i_funct3 == 3'b100 || i_funct3 == 3'b101);
      end
      OP_JAL: begin
        dec_c.is_jump   = 1'b1;
        dec_c.imm_sel   = 3'b100;
        dec_c.aluop1sel = 1'b1;
        dec_c.aluop2sel = 1'b1;
        dec_c.wb_sel    = 2'b10;
        dec_c.reg_we    = 1'b1;
      end
      OP_JALR: begin
        dec_c.is_jump   = 1'b1;
        dec_c.imm_sel   = 3'b001;
        dec_c.aluop2sel = 1'b1;
        dec_c.wb_sel    = 2'b10;
        dec_c.reg_we    = 1'b1;
      end
      OP_LUI: begin
        dec_c.aluop2sel = 1'b1;
        dec_c.alu_ctrl  = 3'b011;
        dec_c.wb_sel    = 2'b01;
        dec_c.reg_we    = 1'b1;
      end
      OP_AUIPC: begin
        dec_c.aluop1sel = 1'b1;
        dec_c.aluop2sel = 1'b1;
        dec_c.wb_sel    = 2'b01;
        dec_c.reg_we    = 1'b1;
      end
      OP_SYSTEM: begin
        dec_c.imm_sel   = 3'b101;
        dec_c.aluop2sel = 1'b1;
        dec_c.alu_ctrl  = 3'b011;
        dec_c.wb_sel    = 2'b01;
        dec_c.reg_we    = 1'b1;
      end
      OP_AMO: begin
        // Only LR/SC are supported; other atomics fall through as illegal.
        if (i_funct7[3:2] == 2'b10) begin
          is_lr_c         = 1'b1;
          dec_c.load      = 1'b1;
          dec_c.imm_sel   = 3'b110;
          dec_c.aluop2sel = 1'b1;
          dec_c.reg_we    = 1'b1;
        end else if (i_funct7[3:2] == 2'b11) begin
          is_sc_c          = 1'b1;
          dec_c.wb_sel     = 2'b11;
          dec_c.imm_sel    = 3'b110;
          dec_c.aluop2sel  = 1'b1;
          dec_c.reg_we     = 1'b1;
          dec_c.store_cond = 1'b1;
        end else begin
          illegal_c = 1'b1;
        end
      end
`ifdef CUSTOM0_DECODE_EN
      OP_CUSTOM0: begin
        dec_c.wb_sel   = 2'b01;
        dec_c.reg_we   = 1'b1;
        dec_c.alu_ctrl = 3'b100;
      end
`endif
      default: begin
        illegal_c = 1'b1;
      end
    endcase
  end

  assign accept_c = i_valid & ~i_stall;

  // Next reservation table: LR sets own bit, SC clears own bit, any store clears all.
  always_comb begin
    res_next_c = res_q;
    if (accept_c) begin
      if (is_lr_c) begin
        res_next_c[i_hart_id] = 1'b1;
      end
      if (is_sc_c) begin
        res_next_c[i_hart_id] = 1'b0;
      end
      if (is_store_c) begin
        res_next_c = '0;
      end
    end
  end

  // Pipeline output registers; everything holds while stalled.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      valid_q   <= 1'b0;
      hart_q    <= '0;
      ctrl_q    <= '0;
      sc_fail_q <= 1'b0;
      illegal_q <= 1'b0;
    end else if (!i_stall) begin
      valid_q <= i_valid;
      if (i_valid) begin
        hart_q    <= i_hart_id;
        ctrl_q    <= dec_c;
        sc_fail_q <= is_sc_c & ~res_q[i_hart_id];
        illegal_q <= illegal_c;
      end else begin
        hart_q    <= '0;
        ctrl_q    <= '0;
        sc_fail_q <= 1'b0;
        illegal_q <= 1'b0;
      end
    end
  end

  // Reservation table register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      res_q <= '0;
    end else begin
      res_q <= res_next_c;
    end
  end

  assign o_valid      = valid_q;
  assign o_hart_id    = hart_q;
  assign o_immSel     = ctrl_q.imm_sel;
  assign o_brmuxsel   = ctrl_q.brmuxsel;
  assign o_br_signed  = ctrl_q.br_signed;
  assign o_is_branch  = ctrl_q.is_branch;
  assign o_is_jump    = ctrl_q.is_jump;
  assign o_aluop1sel  = ctrl_q.aluop1sel;
  assign o_aluop2sel  = ctrl_q.aluop2sel;
  assign o_ALUctrl    = ctrl_q.alu_ctrl;
  assign o_MemWr      = ctrl_q.mem_wr;
  assign o_regWE      = ctrl_q.reg_we;
  assign o_load       = ctrl_q.load;
  assign o_WBSel      = ctrl_q.wb_sel;
  assign o_slt_op     = ctrl_q.slt_op;
  assign o_store_cond = ctrl_q.store_cond;
  assign o_sc_fail    = sc_fail_q;
  assign o_illegal    = illegal_q;
  assign o_res_valid  = res_q;

endmodule

// File: tb/tb_mt_control_unit.sv
// Directed bench for mt_control_unit: decode sweep, LR/SC reservations, stall, async reset.
module tb_mt_control_unit;

  localparam int unsigned NUM_HARTS = 16;
  localparam int unsigned HART_ID_W = 4;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 valid = 1'b0;
  logic                 stall = 1'b0;
  logic [HART_ID_W-1:0] hart = '0;
  logic [6:0]           opcode = '0;
  logic [2:0]           funct3 = '0;
  logic [6:0]           funct7 = '0;

  logic                 o_valid;
  logic [HART_ID_W-1:0] o_hart_id;
  logic [2:0]           o_immSel;
  logic                 o_brmuxsel, o_br_signed, o_is_branch, o_is_jump;
  logic                 o_aluop1sel, o_aluop2sel;
  logic [2:0]           o_ALUctrl;
  logic                 o_MemWr, o_regWE, o_load;
  logic [1:0]           o_WBSel;
  logic                 o_slt_op, o_store_cond, o_sc_fail, o_illegal;
  logic [NUM_HARTS-1:0] o_res_valid;
  logic [18:0]          ctrl_obs;

  int checks = 0;
  int errors = 0;

  mt_control_unit #(.NUM_HARTS(NUM_HARTS)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_valid(valid), .i_stall(stall),
    .i_hart_id(hart), .i_opcode(opcode), .i_funct3(funct3), .i_funct7(funct7),
    .o_valid(o_valid), .o_hart_id(o_hart_id), .o_immSel(o_immSel),
    .o_brmuxsel(o_brmuxsel), .o_br_signed(o_br_signed), .o_is_branch(o_is_branch),
    .o_is_jump(o_is_jump), .o_aluop1sel(o_aluop1sel), .o_aluop2sel(o_aluop2sel),
    .o_ALUctrl(o_ALUctrl), .o_MemWr(o_MemWr), .o_regWE(o_regWE), .o_load(o_load),
    .o_WBSel(o_WBSel), .o_slt_op(o_slt_op), .o_store_cond(o_store_cond),
    .o_sc_fail(o_sc_fail), .o_illegal(o_illegal), .o_res_valid(o_res_valid)
  );

  always #5 clk = ~clk;

  // Field order: immSel | brmux br_signed is_branch is_jump aluop1 aluop2 | ALUctrl | MemWr regWE load | WBSel | slt store_cond
  assign ctrl_obs = {o_immSel, o_brmuxsel, o_br_signed, o_is_branch, o_is_jump,
                     o_aluop1sel, o_aluop2sel, o_ALUctrl, o_MemWr, o_regWE, o_load,
                     o_WBSel, o_slt_op, o_store_cond};

  localparam logic [18:0] C_LUI  = 19'b000_000001_011_010_01_00;
  localparam logic [18:0] C_LOAD = 19'b001_000001_000_011_00_00;
  localparam logic [18:0] C_LR   = 19'b110_000001_000_011_00_00;
  localparam logic [18:0] C_SC   = 19'b110_000001_000_010_11_01;

  typedef struct {
    string       name;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [18:0] ctrl;
    logic        ill;
    logic        scf;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one instruction, then sample 1ns after the capturing edge.
  task automatic step(input logic v, input logic [HART_ID_W-1:0] h, input logic [6:0] op,
                      input logic [2:0] f3, input logic [6:0] f7);
    valid = v; hart = h; opcode = op; funct3 = f3; funct7 = f7;
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs.push_back('{"add",    7'b0110011, 3'b000, 7'b0000000, 19'b000_000000_010_010_01_00, 1'b0, 1'b0});
    vecs.push_back('{"sub",    7'b0110011, 3'b000, 7'b0100000, 19'b000_000000_001_010_01_00, 1'b0, 1'b0});
    vecs.push_back('{"slt",    7'b0110011, 3'b010, 7'b0000000, 19'b000_010000_010_010_11_10, 1'b0, 1'b0});
    vecs.push_back('{"sltu",   7'b0110011, 3'b011, 7'b0000000, 19'b000_000000_010_010_11_10, 1'b0, 1'b0});
    vecs.push_back('{"addi",   7'b0010011, 3'b000, 7'b0000000, 19'b001_100001_010_010_01_00, 1'b0, 1'b0});
    vecs.push_back('{"slti",   7'b0010011, 3'b010, 7'b0000000, 19'b001_110001_010_010_11_10, 1'b0, 1'b0});
    vecs.push_back('{"sltiu",  7'b0010011, 3'b011, 7'b0000000, 19'b001_100001_010_010_11_10, 1'b0, 1'b0});
    vecs.push_back('{"i_f7",   7'b0010011, 3'b000, 7'b0100000, 19'b001_100001_010_010_01_00, 1'b0, 1'b0});
    vecs.push_back('{"load",   7'b0000011, 3'b010, 7'b0000000, C_LOAD,                      1'b0, 1'b0});
    vecs.push_back('{"store",  7'b0100011, 3'b010, 7'b0000000, 19'b010_000001_000_100_00_00, 1'b0, 1'b0});
    vecs.push_back('{"beq",    7'b1100011, 3'b000, 7'b0000000, 19'b011_001011_000_000_00_00, 1'b0, 1'b0});
    vecs.push_back('{"blt",    7'b1100011, 3'b100, 7'b0000000, 19'b011_011011_000_000_00_00, 1'b0, 1'b0});
    vecs.push_back('{"bgeu",   7'b1100011, 3'b111, 7'b0000000, 19'b011_001011_000_000_00_00, 1'b0, 1'b0});
    vecs.push_back('{"jal",    7'b1101111, 3'b000, 7'b0000000, 19'b100_000111_000_010_10_00, 1'b0, 1'b0});
    vecs.push_back('{"jalr",   7'b1100111, 3'b000, 7'b0000000, 19'b001_000101_000_010_10_00, 1'b0, 1'b0});
    vecs.push_back('{"lui",    7'b0110111, 3'b000, 7'b0000000, C_LUI,                       1'b0, 1'b0});
    vecs.push_back('{"auipc",  7'b0010111, 3'b000, 7'b0000000, 19'b000_000011_000_010_01_00, 1'b0, 1'b0});
    vecs.push_back('{"csr",    7'b1110011, 3'b001, 7'b0000000, 19'b101_000001_011_010_01_00, 1'b0, 1'b0});
    vecs.push_back('{"lr",     7'b0101111, 3'b010, 7'b0001000, C_LR,                        1'b0, 1'b0});
    vecs.push_back('{"sc",     7'b0101111, 3'b010, 7'b0001100, C_SC,                        1'b0, 1'b0});
    vecs.push_back('{"amo",    7'b0101111, 3'b010, 7'b0000000, 19'b0,                       1'b1, 1'b0});
    vecs.push_back('{"bad_op", 7'b1111111, 3'b000, 7'b0000000, 19'b0,                       1'b1, 1'b0});
`ifdef CUSTOM0_DECODE_EN
    vecs.push_back('{"custom0", 7'b0001011, 3'b000, 7'b0000000, 19'b000_000000_100_010_01_00, 1'b0, 1'b0});
`else
    vecs.push_back('{"custom0", 7'b0001011, 3'b000, 7'b0000000, 19'b0,                       1'b1, 1'b0});
`endif

    // Asynchronous reset with no clock edge yet.
    #1 rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_ctrl", 64'(ctrl_obs), 64'd0);
    chk("rst_res", 64'(o_res_valid), 64'd0);
    chk("rst_ill", 64'(o_illegal), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Decode sweep on hart 3; store precedes LR, so the SC finds its reservation.
    foreach (vecs[i]) begin
      step(1'b1, 4'd3, vecs[i].op, vecs[i].f3, vecs[i].f7);
      chk({vecs[i].name, "_valid"}, 64'(o_valid), 64'd1);
      chk({vecs[i].name, "_hart"}, 64'(o_hart_id), 64'd3);
      chk({vecs[i].name, "_ctrl"}, 64'(ctrl_obs), 64'(vecs[i].ctrl));
      chk({vecs[i].name, "_ill"}, 64'(o_illegal), 64'(vecs[i].ill));
      chk({vecs[i].name, "_scf"}, 64'(o_sc_fail), 64'(vecs[i].scf));
    end
    chk("sweep_res", 64'(o_res_valid), 64'd0);

    // Bubble: invalid instruction registers as all zero.
    step(1'b0, 4'd3, 7'b0110011, 3'b000, 7'b0);
    chk("bubble_valid", 64'(o_valid), 64'd0);
    chk("bubble_ctrl", 64'(ctrl_obs), 64'd0);
    chk("bubble_ill", 64'(o_illegal), 64'd0);

    // LR/SC pass on hart 5.
    step(1'b1, 4'd5, 7'b0101111, 3'b010, 7'b0001000);
    chk("lr5_res", 64'(o_res_valid), 64'h0020);
    step(1'b1, 4'd5, 7'b0101111, 3'b010, 7'b0001100);
    chk("sc5_scf", 64'(o_sc_fail), 64'd0);
    chk("sc5_res", 64'(o_res_valid), 64'd0);

    // LR twice on hart 4 keeps the bit; second SC has no reservation.
    step(1'b1, 4'd4, 7'b0101111, 3'b010, 7'b0001000);
    step(1'b1, 4'd4, 7'b0101111, 3'b010, 7'b0001000);
    chk("lrlr4_res", 64'(o_res_valid), 64'h0010);
    step(1'b1, 4'd4, 7'b0101111, 3'b010, 7'b0001100);
    chk("sc4a_scf", 64'(o_sc_fail), 64'd0);
    step(1'b1, 4'd4, 7'b0101111, 3'b010, 7'b0001100);
    chk("sc4b_scf", 64'(o_sc_fail), 64'd1);
    chk("sc4b_ctrl", 64'(ctrl_obs), 64'(C_SC));

    // Cross-hart kill: a store on any hart clears every reservation.
    step(1'b1, 4'd2, 7'b0101111, 3'b010, 7'b0001000);
    step(1'b1, 4'd7, 7'b0101111, 3'b010, 7'b0001000);
    chk("lr27_res", 64'(o_res_valid), 64'h0084);
    step(1'b1, 4'd0, 7'b0100011, 3'b010, 7'b0000000);
    chk("st0_res", 64'(o_res_valid), 64'd0);
    step(1'b1, 4'd7, 7'b0101111, 3'b010, 7'b0001100);
    chk("sc7_scf", 64'(o_sc_fail), 64'd1);
    chk("sc7_sc", 64'(o_store_cond), 64'd1);

    // Stall three cycles with an LR on the input, then release.
    step(1'b1, 4'd1, 7'b0110111, 3'b000, 7'b0000000);
    chk("lui1_ctrl", 64'(ctrl_obs), 64'(C_LUI));
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 4'd9, 7'b0101111, 3'b010, 7'b0001000);
      chk("stall_ctrl", 64'(ctrl_obs), 64'(C_LUI));
      chk("stall_hart", 64'(o_hart_id), 64'd1);
      chk("stall_valid", 64'(o_valid), 64'd1);
      chk("stall_res", 64'(o_res_valid), 64'd0);
    end
    stall = 1'b0;
    step(1'b1, 4'd9, 7'b0101111, 3'b010, 7'b0001000);
    chk("unstall_ctrl", 64'(ctrl_obs), 64'(C_LR));
    chk("unstall_hart", 64'(o_hart_id), 64'd9);
    chk("unstall_res", 64'(o_res_valid), 64'h0200);

    // Async reset between edges after an LR.
    step(1'b1, 4'd5, 7'b0101111, 3'b010, 7'b0001000);
    chk("lr5b_res", 64'(o_res_valid), 64'h0220);
    hart = 4'd6;
    #3 rst_n = 1'b0;
    #1;
    chk("arst_res", 64'(o_res_valid), 64'd0);
    chk("arst_valid", 64'(o_valid), 64'd0);
    chk("arst_ctrl", 64'(ctrl_obs), 64'd0);
    @(posedge clk);
    #1;
    chk("arst_hold_valid", 64'(o_valid), 64'd0);
    chk("arst_hold_res", 64'(o_res_valid), 64'd0);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_valid", 64'(o_valid), 64'd1);
    chk("post_rst_hart", 64'(o_hart_id), 64'd6);
    chk("post_rst_res", 64'(o_res_valid), 64'h0040);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
